reg_file: RTL
=============

// Module: reg_file
// PURPOSE
//   General-purpose register file, directly downstream of the register selector.
//   Consumes the selector's active-low one-hot strobes (notOEs/notLoads):
//     - drives the selected register onto the internal data bus;
//     - captures the bus into the load-selected register(s) on the clock edge.
//   r7 is the program counter. It has a dedicated increment path and an
//   always-visible output for memory addressing.
// PARAMETERS
//   WIDTH     16  data width of each register and of the bus
//   RESET_PC  0   value loaded into r7 on reset (WIDTH bits)
// PORTS
//   clock         in   1      system clock, rising-edge active
//   reset         in   1      synchronous, active-high reset
//   regNotOEs     in   8      active-low output enables, bit i = r[i]
//   regNotLoads   in   8      active-low load strobes, bit i = r[i]
//   busIn         in   WIDTH  data bus value to be loaded
//   pcInc         in   1      increment r7 this cycle
//   busOut        out  WIDTH  value driven by the selected register(s)
//   busOE         out  1      high when any regNotOEs bit is low
//   pcOut         out  WIDTH  current r7, continuous
//   oeConflict    out  1      sticky flag: >1 output enable seen low
// BEHAVIOUR
//   Reset (reset high at rising edge):
//     - r0..r6 <= 0; r7 <= RESET_PC; oeConflict <= 0.
//     - Overrides any simultaneous load or pcInc.
//   Load:
//     - At each rising edge, every r[i] with regNotLoads[i]==0 takes busIn.
//     - Multi-bit-low loads are legal (broadcast); all selected registers
//       take the same busIn.
//     - Loaded value is visible on busOut/pcOut the cycle after the edge.
//   Read (combinational, zero latency):
//     - busOut = OR of r[i] over all i with regNotOEs[i]==0 (wired-OR model).
//     - All OEs high: busOut = 0, busOE = 0.
//     - Read in the same cycle as a load of the same register returns the
//       old value.
//   PC (r7), priority per edge: reset > load (regNotLoads[7]==0) > pcInc > hold.
//     - pcInc: r7 <= r7 + 1, modulo 2^WIDTH; all-ones wraps to 0 with no flag.
//     - pcInc together with a load of r7: the load wins and the increment is
//       discarded.
//   Conflict detection:
//     - If regNotOEs has two or more zero bits at a rising edge (reset low),
//       oeConflict <= 1.
//     - It stays set until reset.
//     - busOut still follows the OR rule during the conflict.
//   No state machine; registers plus the sticky flag are the only state.
//   Out of reset, all outputs are defined (no X) for any defined input.
// CONFIGURATION
//   REGFILE_ZERO_REG_EN defined:
//     - r0 is hardwired to 0: regNotLoads[0] is ignored.
//     - With regNotOEs[0] low, r0 contributes 0 to busOut, but busOE still
//       asserts.
//     - r0 still counts toward oeConflict.
//   REGFILE_ZERO_REG_EN undefined: r0 is an ordinary register like r1..r6.
// TESTING
//   1. Reset with RESET_PC=0x0100, then all strobes high
//      -> busOut=0, busOE=0, pcOut=0x0100, oeConflict=0.
//   2. busIn=0xBEEF, regNotLoads=0xF7, one edge, then regNotOEs=0xF7
//      -> busOut=0xBEEF, busOE=1, other registers unchanged.
//   3. r7=0xFFFF, pcInc=1 for one edge -> pcOut=0x0000.
//      Next edge with pcInc=1, regNotLoads=0x7F, busIn=0x1234 -> pcOut=0x1234.
//   4. r1=0x00F0, r2=0x0F00, regNotOEs=0xF9 for one edge
//      -> busOut=0x0FF0, oeConflict=1; oeConflict stays 1 until reset.
//   5. regNotLoads=0x00, busIn=0x5A5A, one edge -> every register reads 0x5A5A.
//      With REGFILE_ZERO_REG_EN, r0 reads 0 instead.
//   6. Assert reset in the same cycle as regNotLoads=0xFD, busIn=0x7777
//      -> r1=0, r7=RESET_PC.

Source files
------------

// File: rtl/reg_file.sv
// Eight-entry register file with wired-OR read bus, broadcast loads and an r7 program counter.
// Define REGFILE_ZERO_REG_EN to hardwire r0 to zero.
module reg_file #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       regNotOEs,
  input  logic [7:0]       regNotLoads,
  input  logic [WIDTH-1:0] busIn,
  input  logic             pcInc,
  output logic [WIDTH-1:0] busOut,
  output logic             busOE,
  output logic [WIDTH-1:0] pcOut,
  output logic             oeConflict
);

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  logic             conflict_q;
  logic             conflict_d;
  logic [7:0]       oeActive;

  assign oeActive = ~regNotOEs;

  // Read side: every enabled register ORs onto the bus, modelling a wired-OR.
  always_comb begin
    busOut = '0;
    for (int i = 0; i < 8; i++) begin
      if (oeActive[i]) begin
        busOut = busOut | regs_q[i];
      end
    end
  end

  assign busOE = |oeActive;
  assign pcOut = regs_q[7];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = regs_q[i];
      if (!regNotLoads[i]) begin
        regs_d[i] = busIn;
      end
    end
    if (regNotLoads[7] && pcInc) begin
      regs_d[7] = regs_q[7] + 1'b1;
    end
`ifdef REGFILE_ZERO_REG_EN
    regs_d[0] = '0;
`endif
    // Clearing the lowest set bit leaves a nonzero value only when two or more enables are active.
    conflict_d = conflict_q | ((oeActive & (oeActive - 8'd1)) != 8'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 7; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[7]  <= RESET_PC;
      conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
      conflict_q <= conflict_d;
    end
  end

  assign oeConflict = conflict_q;

endmodule
